// File: rtl/cache_pkg.sv
// Shared definitions for the L1 data cache: FSM states, line geometry and address field extraction.
package cache_pkg;

  localparam int unsigned BLOCK_SIZE = 4;
  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned LINE_W     = 32 * BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WT_WAIT
  } state_e;

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned idx_w);
    return a >> (idx_w + OFFSET_W);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned idx_w);
    return (a >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] a);
    return a[OFFSET_W-1:2];
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the direct-mapped data cache; full-line fill or single-word update,
// combinational read of the addressed line. Only the valid bits are reset.
module dcache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned IDX_W = $clog2(LINES),
  parameter int unsigned TAG_W = 32 - IDX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              word_we,
  input  logic [1:0]        wr_word_sel,
  input  logic [31:0]       wr_word
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (line_we) valid_d[index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_line;
    end else if (word_we) begin
      data_q[index][{wr_word_sel, 5'b00000} +: 32] <= wr_word;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, write-allocate L1 data cache controller.
// Optional DCACHE_STATS_EN adds hit_count/miss_count outputs.
module data_cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       Address,
  input  logic [31:0]       Write_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Read_data,
  output logic              Stall,
  output logic [31:0]       MemAddress,
  output logic [31:0]       MemWrite_data,
  output logic              ReadMiss,
  output logic              MemWriteThrough,
  input  logic [LINE_W-1:0] MemRead_data,
  input  logic              ReadReady,
  input  logic              WriteReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - OFFSET_W;

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  index;
  logic [1:0]        word;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              line_we, word_we;
  logic [LINE_W-1:0] fill_line;

  assign tag   = TAG_W'(addr_tag(Address, IDX_W));
  assign index = IDX_W'(addr_index(Address, IDX_W));
  assign word  = addr_word(Address);
  assign hit   = rd_valid && (rd_tag == tag);

  assign MemAddress    = Address;
  assign MemWrite_data = Write_data;

  dcache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk         (Clk),
    .rst         (Rst),
    .index       (index),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .line_we     (line_we),
    .wr_tag      (tag),
    .wr_line     (fill_line),
    .word_we     (word_we),
    .wr_word_sel (word),
    .wr_word     (Write_data)
  );

  // Memory returns the pre-write block on a store miss, so the store word is merged into the fill.
  always_comb begin
    fill_line = MemRead_data;
    if (MemWrite) fill_line[{word, 5'b00000} +: 32] = Write_data;
  end

  // done_q marks a store whose memory transaction already completed; it retires next IDLE cycle.
  always_comb begin
    state_d         = state_q;
    done_d          = done_q;
    Stall           = 1'b0;
    ReadMiss        = 1'b0;
    MemWriteThrough = 1'b0;
    Read_data       = '0;
    line_we         = 1'b0;
    word_we         = 1'b0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (MemRead) begin
          if (hit) begin
            Read_data = rd_line[{word, 5'b00000} +: 32];
          end else begin
            ReadMiss = 1'b1;
            Stall    = 1'b1;
            state_d  = RD_WAIT;
          end
        end else if (MemWrite && !done_q) begin
          MemWriteThrough = 1'b1;
          Stall           = 1'b1;
          if (hit) begin
            word_we = 1'b1;
            state_d = WT_WAIT;
          end else begin
            ReadMiss = 1'b1;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        ReadMiss        = 1'b1;
        MemWriteThrough = MemWrite;
        Stall           = 1'b1;
        if (ReadReady) begin
          line_we = 1'b1;
          done_d  = MemWrite;
          state_d = IDLE;
        end
      end
      WT_WAIT: begin
        MemWriteThrough = 1'b1;
        Stall           = 1'b1;
        if (WriteReady) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic        missed_q, missed_d;
  logic        retire;

  // An access is counted once, when it retires; missed_q remembers that it went through a fill.
  assign retire = (state_q == IDLE) && ((MemRead && hit) || (MemWrite && done_q));

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    missed_d     = missed_q;
    if (state_q == IDLE && state_d == RD_WAIT) missed_d = 1'b1;
    if (retire) begin
      missed_d = 1'b0;
      if (missed_q) miss_count_d = miss_count_q + 32'd1;
      else          hit_count_d  = hit_count_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      missed_q     <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      missed_q     <= missed_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench for data_cache_controller with a fixed-latency block memory model.
module tb_data_cache_controller;

  localparam int unsigned LINES = 64;
  localparam int          LAT   = 19;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [31:0]  Address = '0;
  logic [31:0]  Write_data = '0;
  logic         MemRead = 1'b0;
  logic         MemWrite = 1'b0;
  logic [31:0]  Read_data;
  logic         Stall;
  logic [31:0]  MemAddress;
  logic [31:0]  MemWrite_data;
  logic         ReadMiss;
  logic         MemWriteThrough;
  logic [127:0] MemRead_data = '0;
  logic         ReadReady = 1'b0;
  logic         WriteReady = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  always #5 Clk = ~Clk;

  data_cache_controller #(.LINES(LINES)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Address         (Address),
    .Write_data      (Write_data),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Read_data       (Read_data),
    .Stall           (Stall),
    .MemAddress      (MemAddress),
    .MemWrite_data   (MemWrite_data),
    .ReadMiss        (ReadMiss),
    .MemWriteThrough (MemWriteThrough),
    .MemRead_data    (MemRead_data),
    .ReadReady       (ReadReady),
    .WriteReady      (WriteReady)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Background memory contents before any store.
  function automatic logic [31:0] bg(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  logic [31:0] wmem [int unsigned];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return bg(a);
  endfunction

  // Memory: samples a request on the first edge, pulses the ready LAT cycles later.
  logic busy = 1'b0;
  logic is_rd = 1'b0;
  int   cnt = 0;
  always @(posedge Clk) begin
    if (Rst) begin
      busy       <= 1'b0;
      cnt        <= 0;
      ReadReady  <= 1'b0;
      WriteReady <= 1'b0;
    end else begin
      ReadReady  <= 1'b0;
      WriteReady <= 1'b0;
      if (busy) begin
        if (cnt == LAT - 1) begin
          busy <= 1'b0;
          if (is_rd) ReadReady  <= 1'b1;
          else       WriteReady <= 1'b1;
        end else begin
          cnt <= cnt + 1;
        end
      end else if (!ReadReady && !WriteReady && (ReadMiss || MemWriteThrough)) begin
        busy  <= 1'b1;
        cnt   <= 1;
        is_rd <= ReadMiss;
        for (int w = 0; w < 4; w++)
          MemRead_data[32*w +: 32] <= mem_rd({MemAddress[31:4], 2'(w), 2'b00});
        if (MemWriteThrough) wmem[MemAddress] = MemWrite_data;
      end
    end
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    int          stall;
    int          rm;
    int          wt;
    string       name;
  } exp_t;

  exp_t sbq[$];

  // Monitor: counts stall/request cycles of the current access and checks it when it retires.
  int st_c = 0, rm_c = 0, wt_c = 0;
  always @(negedge Clk) begin
    if (Rst) begin
      st_c = 0; rm_c = 0; wt_c = 0;
    end else if (MemRead || MemWrite) begin
      if (Stall) begin
        st_c++;
        if (ReadMiss) rm_c++;
        if (MemWriteThrough) wt_c++;
      end else begin
        exp_t e;
        if (sbq.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_stall"}, 32'(st_c), 32'(e.stall));
          chk({e.name, "_readmiss"}, 32'(rm_c), 32'(e.rm));
          chk({e.name, "_writethrough"}, 32'(wt_c), 32'(e.wt));
          if (e.is_rd) chk({e.name, "_data"}, Read_data, e.data);
        end
        st_c = 0; rm_c = 0; wt_c = 0;
      end
    end
  end

  task automatic access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int ex_st, input int ex_rm,
                        input int ex_wt, input string name);
    exp_t e;
    bit   ok;
    e.is_rd = rd; e.data = exp_data; e.stall = ex_st; e.rm = ex_rm; e.wt = ex_wt; e.name = name;
    sbq.push_back(e);
    @(posedge Clk); #1;
    Address = addr; Write_data = wdata; MemRead = rd; MemWrite = !rd;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (!Stall) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 32'd1, 32'd0);
    @(posedge Clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  localparam int M = LAT + 1;

  initial begin
    Address = 32'h1234_5678; Write_data = 32'hCAFE_F00D;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_readmiss", {31'd0, ReadMiss}, 32'd0);
    chk("rst_writethrough", {31'd0, MemWriteThrough}, 32'd0);
    chk("rst_read_data", Read_data, 32'd0);
    chk("rst_memaddress", MemAddress, 32'h1234_5678);
    chk("rst_memwrite_data", MemWrite_data, 32'hCAFE_F00D);

    access(1, 32'h40, 0, bg(32'h40), M, M, 0, "lw40_miss");
    access(1, 32'h44, 0, bg(32'h44), 0, 0, 0, "lw44_hit");
    access(1, 32'h4C, 0, bg(32'h4C), 0, 0, 0, "lw4c_hit");

    access(0, 32'h44, 32'hDEAD_BEEF, 0, M, 0, M, "sw44_hit");
    access(1, 32'h44, 0, 32'hDEAD_BEEF, 0, 0, 0, "lw44_after_sw");

    access(0, 32'h100, 32'h1234_5678, 0, M, M, M, "sw100_miss");
    access(1, 32'h100, 0, 32'h1234_5678, 0, 0, 0, "lw100_merged");
    access(1, 32'h104, 0, bg(32'h104), 0, 0, 0, "lw104_hit");

    access(1, 32'h40, 0, bg(32'h40), 0, 0, 0, "lw40_hit");
    access(1, 32'h40 + 16 * LINES, 0, bg(32'h40 + 16 * LINES), M, M, 0, "lw440_evict");
    access(1, 32'h40, 0, bg(32'h40), M, M, 0, "lw40_refill");
    access(1, 32'h44, 0, 32'hDEAD_BEEF, 0, 0, 0, "lw44_from_mem");

    // Reset in the middle of a miss.
    @(posedge Clk); #1;
    Address = 32'h300; MemRead = 1'b1;
    repeat (5) @(posedge Clk);
    #1 Rst = 1'b1; MemRead = 1'b0;
    @(posedge Clk); #1 Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_stall", {31'd0, Stall}, 32'd0);
    chk("midrst_readmiss", {31'd0, ReadMiss}, 32'd0);
    chk("midrst_writethrough", {31'd0, MemWriteThrough}, 32'd0);
    access(1, 32'h40, 0, bg(32'h40), M, M, 0, "lw40_after_rst");
    access(1, 32'h44, 0, 32'hDEAD_BEEF, 0, 0, 0, "lw44_after_rst");

`ifdef DCACHE_STATS_EN
    @(negedge Clk);
    chk("hit_count", hit_count, 32'd1);
    chk("miss_count", miss_count, 32'd1);
`endif

    repeat (2) @(posedge Clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
